alu_serial_ctrl: RTL and testbench
==================================

// Module: alu_serial_ctrl
// PURPOSE
//   Bit-serial sequencer that drives one external combinational alu1 slice.
//   - Accepts a WIDTH-bit operation over a valid/ready handshake.
//   - Feeds the slice one bit per cycle, LSB first, and chains carry/borrow between bits.
//   - Assembles the result and status flags, then presents them on a valid/ready result port.
//   - Sits between the instruction/decode logic and the alu1 slice; it is the initiator of the slice interface.
// PARAMETERS
//   WIDTH  4  operand/result width in bits; legal range 2..32
// PORTS
//   clk              in   1      single clock; all state updates on rising edge
//   rst              in   1      synchronous, active-high reset
//   op_valid_i       in   1      operation request valid
//   op_ready_o       out  1      controller can accept an operation (high only in IDLE)
//   op_sel_i         in   3      opcode: 7 AND, 6 NOT, 5 OR, 4 XOR, 3 ADD, 2 SUB, 1 TRANSFER, 0 TEST
//   op_a_i           in   WIDTH  operand A
//   op_b_i           in   WIDTH  operand B (ignored by NOT/TRANSFER/TEST)
//   op_cin_i         in   1      carry-in for ADD; ignored by all other opcodes
//   alu_a_o          out  1      slice input a: A[bit]
//   alu_b_o          out  1      slice input b: B[bit]
//   alu_carry_in_o   out  1      slice carry_in / borrow_in
//   alu_select_o     out  3      slice select: the latched opcode
//   alu_out_i        in   1      slice out
//   alu_carry_out_i  in   1      slice carry_out / borrow_out
//   res_valid_o      out  1      result and flags valid
//   res_ready_i      in   1      consumer accepts result
//   res_o            out  WIDTH  result
//   res_carry_o      out  1      final carry (ADD) or borrow (SUB); 0 for all other opcodes
//   res_zero_o       out  1      res_o == 0 (TEST: A == 0)
//   res_neg_o        out  1      MSB of res_o (TEST: A[WIDTH-1])
//   res_ovf_o        out  1      signed overflow (ADD/SUB only; otherwise 0)
//   busy_o           out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset: rst sampled high -> state IDLE, bit counter 0, all result registers/flags 0.
//     - In the first cycle after reset: res_valid_o=0, busy_o=0, op_ready_o=1, all alu_*_o=0.
//     - Reset overrides every other input, in any state, including mid-RUN; a partial result is discarded.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//     - IDLE: op_ready_o=1. On op_valid_i&op_ready_o, latch op_sel_i, op_a_i, op_b_i.
//       Carry register initial value: op_cin_i for ADD, 0 otherwise. Counter k=0. Go to RUN.
//     - RUN: alu_a_o=A[k], alu_b_o=B[k], alu_carry_in_o=carry register, alu_select_o=opcode.
//       At each edge: result bit k <= alu_out_i (TRANSFER/TEST: <= A[k], since the slice outputs 0);
//       carry register <= alu_carry_out_i; k++.
//       After bit WIDTH-1 is sampled -> DONE. Exactly WIDTH RUN cycles.
//     - DONE: res_valid_o=1; res_o and flags held stable until res_valid_o&res_ready_i, then -> IDLE.
//   Latency: res_valid_o rises WIDTH+1 cycles after the accepting edge. Throughput: one op per WIDTH+2 cycles minimum.
//   op_valid_i while not IDLE: ignored, not queued.
//   IDLE/DONE: alu_a_o, alu_b_o, alu_carry_in_o driven 0; alu_select_o holds the last opcode.
//   Flags are computed at the transition into DONE:
//     - ADD: carry = final carry_out; ovf = carry_in(MSB) ^ carry_out(MSB).
//     - SUB (A-B): carry = final borrow; ovf = (A[msb]^B[msb]) & (A[msb]^res[msb]).
//     - Logic/TRANSFER: carry=0, ovf=0; zero/neg taken from the result.
//   TEST: res_o keeps its previous value (not overwritten); zero/neg taken from A; carry=0, ovf=0.
// TESTING
//   - ADD A=7 B=9 cin=0 -> after 5 cycles res=0, carry=1, zero=1, ovf=0, neg=0.
//   - ADD A=7 B=1 -> res=8, ovf=1, neg=1, carry=0. ADD A=F B=0 cin=1 -> res=0, carry=1.
//   - SUB A=3 B=5 -> res=E, carry(borrow)=1, neg=1, ovf=0. SUB A=8 B=1 -> res=7, ovf=1.
//   - XOR A=A B=6 -> res=C, carry=0. Check alu_select_o=4 and alu_a_o sequence 0,1,0,1 over RUN.
//   - Hold res_ready_i low 5 cycles in DONE while pulsing op_valid_i -> res stable, op_ready_o=0, op dropped.
//   - rst high at RUN bit 2 -> next cycle IDLE, res_valid_o=0, res_o=0. Then TEST A=0 -> zero=1, res_o=0.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// Bundles the operation, alu1-slice and result channels of the bit-serial ALU sequencer.
// Latency: none, wires only.
// Backpressure: op_ready_o / res_ready_i carry the valid-ready handshakes; the slice channel has none.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 4
);
    // Operation request channel
    logic             op_valid_i;
    logic             op_ready_o;
    logic [2:0]       op_sel_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             op_cin_i;

    // alu1 slice channel
    logic             alu_a_o;
    logic             alu_b_o;
    logic             alu_carry_in_o;
    logic [2:0]       alu_select_o;
    logic             alu_out_i;
    logic             alu_carry_out_i;

    // Result channel
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] res_o;
    logic             res_carry_o;
    logic             res_zero_o;
    logic             res_neg_o;
    logic             res_ovf_o;
    logic             busy_o;

    // Controller side: it initiates the slice interface and the result stream.
    modport master (
        input  op_valid_i, op_sel_i, op_a_i, op_b_i, op_cin_i,
        output op_ready_o,
        output alu_a_o, alu_b_o, alu_carry_in_o, alu_select_o,
        input  alu_out_i, alu_carry_out_i,
        output res_valid_o, res_o, res_carry_o, res_zero_o, res_neg_o, res_ovf_o, busy_o,
        input  res_ready_i
    );

    // Environment side: decode logic, the alu1 slice and the result consumer.
    modport slave (
        output op_valid_i, op_sel_i, op_a_i, op_b_i, op_cin_i,
        input  op_ready_o,
        input  alu_a_o, alu_b_o, alu_carry_in_o, alu_select_o,
        output alu_out_i, alu_carry_out_i,
        input  res_valid_o, res_o, res_carry_o, res_zero_o, res_neg_o, res_ovf_o, busy_o,
        output res_ready_i
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one combinational alu1 slice, LSB first, with carry/borrow chaining.
// Latency: result valid WIDTH+1 cycles after the accepting cycle; one op per WIDTH+2 cycles at best.
// Backpressure: op_ready_o only in IDLE (requests elsewhere are dropped); result held until res_ready_i.
module alu_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_serial_ctrl_if.master bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_TEST     = 3'd0;
    localparam logic [2:0] OP_TRANSFER = 3'd1;
    localparam logic [2:0] OP_SUB      = 3'd2;
    localparam logic [2:0] OP_ADD      = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]       opcode_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] k_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] res_q;
    logic             res_carry_q;
    logic             res_zero_q;
    logic             res_neg_q;
    logic             res_ovf_q;

    logic             accept;
    logic             last_cycle;
    logic             op_ready;
    logic             busy;
    logic             res_valid;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             bit_in;
    logic             pass_through;
    logic [WIDTH-1:0] final_res;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake / slice-drive outputs
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_cycle = 1'b0;
        op_ready   = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_cin  = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (bus.op_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                slice_a   = a_q[k_q];
                slice_b   = b_q[k_q];
                slice_cin = carry_q;
                if (k_q == LAST_BIT) begin
                    last_cycle = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (bus.res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // TRANSFER and TEST get nothing useful from the slice, so A is copied straight through.
    assign pass_through = (opcode_q == OP_TRANSFER) || (opcode_q == OP_TEST);
    assign bit_in       = pass_through ? a_q[k_q] : bus.alu_out_i;
    // Full result as it will stand once the MSB currently on the slice is captured.
    assign final_res    = {bit_in, work_q[WIDTH-2:0]};

    // Operand latch, bit-serial accumulation and flag capture on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            work_q      <= '0;
            res_q       <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q <= bus.op_sel_i;
                a_q      <= bus.op_a_i;
                b_q      <= bus.op_b_i;
                carry_q  <= (bus.op_sel_i == OP_ADD) ? bus.op_cin_i : 1'b0;
                k_q      <= '0;
                work_q   <= '0;
            end
            if (state_q == S_RUN) begin
                work_q[k_q] <= bit_in;
                carry_q     <= bus.alu_carry_out_i;
                k_q         <= k_q + CNT_W'(1);
            end
            if (last_cycle) begin
                res_carry_q <= 1'b0;
                res_ovf_q   <= 1'b0;
                case (opcode_q)
                    OP_ADD: begin
                        res_carry_q <= bus.alu_carry_out_i;
                        res_ovf_q   <= carry_q ^ bus.alu_carry_out_i;
                    end
                    OP_SUB: begin
                        res_carry_q <= bus.alu_carry_out_i;
                        res_ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                       (a_q[WIDTH-1] ^ final_res[WIDTH-1]);
                    end
                    default: begin
                    end
                endcase
                // TEST only reports on A and leaves the previous result visible.
                if (opcode_q == OP_TEST) begin
                    res_zero_q <= (a_q == '0);
                    res_neg_q  <= a_q[WIDTH-1];
                end else begin
                    res_q      <= final_res;
                    res_zero_q <= (final_res == '0);
                    res_neg_q  <= final_res[WIDTH-1];
                end
            end
        end
    end

    assign bus.op_ready_o     = op_ready;
    assign bus.busy_o         = busy;
    assign bus.res_valid_o    = res_valid;
    assign bus.alu_a_o        = slice_a;
    assign bus.alu_b_o        = slice_b;
    assign bus.alu_carry_in_o = slice_cin;
    assign bus.alu_select_o   = opcode_q;
    assign bus.res_o          = res_q;
    assign bus.res_carry_o    = res_carry_q;
    assign bus.res_zero_o     = res_zero_q;
    assign bus.res_neg_o      = res_neg_q;
    assign bus.res_ovf_o      = res_ovf_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: directed ops against an arithmetic model plus literal expectations.
// Latency: a per-cycle compare process checks handshake timing, slice drive and held results.
// Backpressure: exercises DONE stalls with dropped requests and a mid-RUN synchronous reset.
module tb_alu_serial_ctrl;
    localparam int W = 4;

    logic clk;
    logic rst;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected-behaviour state owned by the stimulus process
    logic         armed   = 1'b0;
    int           run_idx = -1;
    logic         in_done = 1'b0;
    logic [2:0]   last_sel = 3'd0;
    logic [W-1:0] cur_a = '0;
    logic [W-1:0] cur_b = '0;
    logic         cur_cin = 1'b0;
    logic [W-1:0] model_res = '0;
    logic         e_c = 1'b0;
    logic         e_z = 1'b0;
    logic         e_n = 1'b0;
    logic         e_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference alu1 slice: one bit of the selected operation.
    always_comb begin
        bus.alu_out_i       = 1'b0;
        bus.alu_carry_out_i = 1'b0;
        case (bus.alu_select_o)
            3'd7: bus.alu_out_i = bus.alu_a_o & bus.alu_b_o;
            3'd6: bus.alu_out_i = ~bus.alu_a_o;
            3'd5: bus.alu_out_i = bus.alu_a_o | bus.alu_b_o;
            3'd4: bus.alu_out_i = bus.alu_a_o ^ bus.alu_b_o;
            3'd3: begin
                bus.alu_out_i       = bus.alu_a_o ^ bus.alu_b_o ^ bus.alu_carry_in_o;
                bus.alu_carry_out_i = (bus.alu_a_o & bus.alu_b_o) |
                                      (bus.alu_a_o & bus.alu_carry_in_o) |
                                      (bus.alu_b_o & bus.alu_carry_in_o);
            end
            3'd2: begin
                bus.alu_out_i       = bus.alu_a_o ^ bus.alu_b_o ^ bus.alu_carry_in_o;
                bus.alu_carry_out_i = (~bus.alu_a_o & bus.alu_b_o) |
                                      (~bus.alu_a_o & bus.alu_carry_in_o) |
                                      (bus.alu_b_o & bus.alu_carry_in_o);
            end
            default: begin
            end
        endcase
    end

    // Whole-word model of one operation
    function automatic void model(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic [W-1:0] prev,
                                  output logic [W-1:0] r, output logic c, output logic z,
                                  output logic n, output logic v);
        logic [W:0] sum;
        r = prev;
        c = 1'b0;
        v = 1'b0;
        case (s)
            3'd7: r = a & b;
            3'd6: r = ~a;
            3'd5: r = a | b;
            3'd4: r = a ^ b;
            3'd3: begin
                sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                r   = sum[W-1:0];
                c   = sum[W];
                v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: begin
                r = a - b;
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: r = a;
            default: r = prev;
        endcase
        z = (s == 3'd0) ? (a == '0) : (r == '0);
        n = (s == 3'd0) ? a[W-1] : r[W-1];
    endfunction

    // Carry/borrow that must enter bit k: derived from the sum/difference of the lower k bits.
    function automatic logic exp_cin(input int k);
        longint m;
        longint la;
        longint lb;
        m  = (longint'(1) << k) - 1;
        la = longint'(cur_a) & m;
        lb = longint'(cur_b) & m;
        if (last_sel == 3'd3) return ((la + lb + longint'(cur_cin)) >> k) & 1;
        if (last_sel == 3'd2) return (la < lb);
        return 1'b0;
    endfunction

    // Per-cycle comparison of every DUT output against the expected behaviour
    always @(negedge clk) begin
        if (armed && !rst) begin
            chk("op_ready", 32'(bus.op_ready_o), 32'(!((run_idx >= 0) || in_done)));
            chk("busy", 32'(bus.busy_o), 32'((run_idx >= 0) || in_done));
            chk("res_valid", 32'(bus.res_valid_o), 32'(in_done));
            chk("alu_select", 32'(bus.alu_select_o), 32'(last_sel));
            chk("res_held", 32'(bus.res_o), 32'(model_res));
            if (run_idx >= 0) begin
                chk("alu_a", 32'(bus.alu_a_o), 32'(cur_a[run_idx]));
                chk("alu_b", 32'(bus.alu_b_o), 32'(cur_b[run_idx]));
                chk("alu_cin", 32'(bus.alu_carry_in_o), 32'(exp_cin(run_idx)));
            end else begin
                chk("alu_idle_abc", 32'({bus.alu_a_o, bus.alu_b_o, bus.alu_carry_in_o}), 32'(0));
            end
            if (in_done) begin
                chk("res_carry", 32'(bus.res_carry_o), 32'(e_c));
                chk("res_zero", 32'(bus.res_zero_o), 32'(e_z));
                chk("res_neg", 32'(bus.res_neg_o), 32'(e_n));
                chk("res_ovf", 32'(bus.res_ovf_o), 32'(e_v));
            end
        end
    end

    // One full operation; lf = {carry, zero, neg, ovf} hand-computed expectations.
    task automatic do_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input int hold, input logic [W-1:0] lres, input logic [3:0] lf);
        logic [W-1:0] r;
        logic c, z, n, v;
        bus.op_sel_i   = s;
        bus.op_a_i     = a;
        bus.op_b_i     = b;
        bus.op_cin_i   = ci;
        bus.op_valid_i = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the request bus so that only latched operands can give the right answer.
        bus.op_valid_i = 1'b0;
        bus.op_sel_i   = ~s;
        bus.op_a_i     = ~a;
        bus.op_b_i     = ~b;
        bus.op_cin_i   = ~ci;
        last_sel = s;
        cur_a    = a;
        cur_b    = b;
        cur_cin  = ci;
        run_idx  = 0;
        model(s, a, b, ci, model_res, r, c, z, n, v);
        for (int i = 0; i < W; i++) begin
            @(posedge clk);
            #1;
            run_idx = (i == W - 1) ? -1 : i + 1;
        end
        model_res = r;
        e_c = c;
        e_z = z;
        e_n = n;
        e_v = v;
        in_done = 1'b1;
        chk("lit_res", 32'(bus.res_o), 32'(lres));
        chk("lit_flags", 32'({bus.res_carry_o, bus.res_zero_o, bus.res_neg_o, bus.res_ovf_o}), 32'(lf));
        // Stall in DONE while new requests knock; none of them may be taken.
        for (int h = 0; h < hold; h++) begin
            bus.op_valid_i = (h % 2 == 0);
            bus.op_sel_i   = 3'd3;
            bus.op_a_i     = 4'h1;
            bus.op_b_i     = 4'h1;
            @(posedge clk);
            #1;
        end
        bus.op_valid_i  = 1'b0;
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready_i = 1'b0;
        in_done = 1'b0;
    endtask

    initial begin
        bus.op_valid_i  = 1'b0;
        bus.op_sel_i    = 3'd0;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.op_cin_i    = 1'b0;
        bus.res_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        armed = 1'b1;
        chk("rst_flags", 32'({bus.res_carry_o, bus.res_zero_o, bus.res_neg_o, bus.res_ovf_o}), 32'(0));
        chk("rst_ready", 32'(bus.op_ready_o), 32'(1));
        @(posedge clk);
        #1;

        //      op    A     B     cin hold  res   {c,z,n,v}
        do_op(3'd3, 4'h7, 4'h9, 1'b0, 0, 4'h0, 4'b1100);
        do_op(3'd3, 4'h7, 4'h1, 1'b0, 0, 4'h8, 4'b0011);
        do_op(3'd3, 4'hF, 4'h0, 1'b1, 0, 4'h0, 4'b1100);
        do_op(3'd2, 4'h3, 4'h5, 1'b0, 0, 4'hE, 4'b1010);
        do_op(3'd2, 4'h8, 4'h1, 1'b0, 0, 4'h7, 4'b0001);
        do_op(3'd2, 4'h5, 4'h5, 1'b1, 0, 4'h0, 4'b0100);
        do_op(3'd4, 4'hA, 4'h6, 1'b0, 5, 4'hC, 4'b0010);
        do_op(3'd0, 4'h9, 4'h3, 1'b0, 0, 4'hC, 4'b0010);
        do_op(3'd7, 4'hC, 4'hA, 1'b1, 1, 4'h8, 4'b0010);
        do_op(3'd5, 4'h5, 4'h2, 1'b0, 0, 4'h7, 4'b0000);
        do_op(3'd6, 4'h5, 4'hF, 1'b0, 0, 4'hA, 4'b0010);
        do_op(3'd1, 4'h0, 4'hF, 1'b1, 0, 4'h0, 4'b0100);
        do_op(3'd3, 4'h8, 4'h8, 1'b1, 2, 4'h1, 4'b1001);

        // Reset while bit 2 is on the slice: the partial ADD must vanish.
        bus.op_sel_i   = 3'd3;
        bus.op_a_i     = 4'h5;
        bus.op_b_i     = 4'h3;
        bus.op_cin_i   = 1'b0;
        bus.op_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.op_valid_i = 1'b0;
        last_sel = 3'd3;
        cur_a    = 4'h5;
        cur_b    = 4'h3;
        cur_cin  = 1'b0;
        run_idx  = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            run_idx = run_idx + 1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        run_idx   = -1;
        in_done   = 1'b0;
        last_sel  = 3'd0;
        model_res = '0;
        chk("rst_mid_valid", 32'(bus.res_valid_o), 32'(0));
        chk("rst_mid_res", 32'(bus.res_o), 32'(0));
        @(posedge clk);
        #1;
        do_op(3'd0, 4'h0, 4'h7, 1'b1, 0, 4'h0, 4'b0100);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
